// File: rtl/word_serializer_16to1_pkg.sv
// Shared definitions for the 16-word serializer.
//   NUM_WORDS : number of words in one input vector
//   SEL_W     : width of the beat counter / mux select
//   state_t   : serializer control state
package word_serializer_16to1_pkg;

    localparam int unsigned NUM_WORDS = 16;
    localparam int unsigned SEL_W     = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer_16to1_multiplexer.sv
// 16:1 word multiplexer (M bits per word).
//   in_data  : NUM_WORDS*M word vector, word k at [(k+1)*M-1 : k*M]
//   sel      : index of the word to route out
//   out_data : selected word
module multiplexer_16to1
    import word_serializer_16to1_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic [NUM_WORDS*M-1:0] in_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [M-1:0]           out_data
);

    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (sel == SEL_W'(k)) begin
                out_data = in_data[k*M +: M];
            end
        end
    end

endmodule

// File: rtl/word_serializer_16to1.sv
// Wide-to-narrow serializer: captures one 16-word vector per input handshake
// and streams words 0..in_len_m1 out, one per output handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data, in_len_m1  : word vector and (word count - 1)
//   in_valid / in_ready : input handshake
//   out_data, out_idx   : current word and its index (mux select)
//   out_valid/out_ready : output handshake
//   out_last            : current word is the final one of the vector
module word_serializer_16to1
    import word_serializer_16to1_pkg::*;
#(
    parameter int unsigned M = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_WORDS*M-1:0] in_data,
    input  logic [SEL_W-1:0]       in_len_m1,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [M-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_idx
);

    state_t                 state_q, state_d;
    logic [NUM_WORDS*M-1:0] buf_q, buf_d;
    logic [SEL_W-1:0]       len_q, len_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   load;

    // Mux inputs are registers only, so out_data has no path from any input.
    multiplexer_16to1 #(.M(M)) u_mux (
        .in_data  (buf_q),
        .sel      (sel_q),
        .out_data (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        len_d     = len_q;
        sel_d     = sel_q;
        out_idx   = sel_q;
        out_valid = (state_q == STREAM);
        out_last  = (state_q == STREAM) && (sel_q == len_q);
        // Accepting on the final beat lets the next vector follow with no bubble.
        in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
        load      = in_valid && in_ready;

        if (load) begin
            buf_d   = in_data;
            len_d   = in_len_m1;
            sel_d   = '0;
            state_d = STREAM;
        end else if (out_valid && out_ready) begin
            if (out_last) begin
                state_d = IDLE;
                sel_d   = '0;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_word_serializer_16to1.sv
module tb_word_serializer_16to1;

    localparam int unsigned M = 8;

    typedef struct {
        logic [7:0] w;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_len_m1;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   out_idx;

    int n_cmp = 0;
    int n_err = 0;

    word_serializer_16to1 #(.M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_len_m1 (in_len_m1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one vector for a single cycle; reports whether it was accepted.
    task automatic send_vec(input logic [127:0] v, input logic [3:0] l, output logic acc);
        in_data   = v;
        in_len_m1 = l;
        in_valid  = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        n_cmp++; if (out_idx !== 4'd0) begin n_err++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
        n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_first_vector();
        logic [127:0] v;
        logic acc;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'h10 + 8'(k);
        out_ready = 1'b1;
        send_vec(v, 4'd15, acc);
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL first_accept: got %b expected 1", acc); end
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(b)) begin n_err++;
                $display("FAIL first_data[%0d]: got v=%b d=%h expected v=1 d=%h", b, out_valid, out_data, 8'h10 + 8'(b)); end
            n_cmp++; if (out_idx !== 4'(b) || out_last !== (b == 15)) begin n_err++;
                $display("FAIL first_idx_last[%0d]: got idx=%0d last=%b expected idx=%0d last=%b", b, out_idx, out_last, b, b == 15); end
            n_cmp++; if (in_ready !== (b == 15)) begin n_err++;
                $display("FAIL first_in_ready[%0d]: got %b expected %b", b, in_ready, b == 15); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_end_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [127:0] v;
        logic acc;
        v = rand_vec();
        v[7:0] = 8'hA5;
        out_ready = 1'b1;
        send_vec(v, 4'd0, acc);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b1 || out_idx !== 4'd0) begin n_err++;
            $display("FAIL single_beat: got v=%b d=%h last=%b idx=%0d expected 1/a5/1/0", out_valid, out_data, out_last, out_idx); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_after: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] v;
        logic acc;
        v = rand_vec();
        out_ready = 1'b1;
        send_vec(v, 4'd3, acc);
        @(negedge clk);
        n_cmp++; if (out_data !== v[7:0] || out_idx !== 4'd0) begin n_err++;
            $display("FAIL bp_beat0: got d=%h idx=%0d expected d=%h idx=0", out_data, out_idx, v[7:0]); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[15:8] || out_idx !== 4'd1 || out_last !== 1'b0 || in_ready !== 1'b0) begin n_err++;
                $display("FAIL bp_stall[%0d]: got v=%b d=%h idx=%0d last=%b rdy=%b expected 1/%h/1/0/0",
                         s, out_valid, out_data, out_idx, out_last, in_ready, v[15:8]); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[b*8 +: 8] || out_idx !== 4'(b) || out_last !== (b == 3)) begin n_err++;
                $display("FAIL bp_resume[%0d]: got v=%b d=%h idx=%0d last=%b expected 1/%h/%0d/%b",
                         b, out_valid, out_data, out_idx, out_last, v[b*8 +: 8], b, b == 3); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] va, vb;
        logic [3:0]   lb;
        logic acc;
        va = rand_vec();
        vb = rand_vec();
        lb = 4'($urandom_range(0, 15));
        out_ready = 1'b1;
        send_vec(va, 4'd1, acc);
        @(negedge clk);
        n_cmp++; if (out_data !== va[7:0] || in_ready !== 1'b0) begin n_err++;
            $display("FAIL b2b_a0: got d=%h rdy=%b expected %h/0", out_data, in_ready, va[7:0]); end
        @(posedge clk); #1;
        in_data = vb; in_len_m1 = lb; in_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_data !== va[15:8] || out_last !== 1'b1 || in_ready !== 1'b1) begin n_err++;
            $display("FAIL b2b_a1: got d=%h last=%b rdy=%b expected %h/1/1", out_data, out_last, in_ready, va[15:8]); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        for (int b = 0; b <= int'(lb); b++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== vb[b*8 +: 8] || out_idx !== 4'(b) || out_last !== (b == int'(lb))) begin n_err++;
                $display("FAIL b2b_b[%0d]: got v=%b d=%h idx=%0d last=%b expected 1/%h/%0d/%b",
                         b, out_valid, out_data, out_idx, out_last, vb[b*8 +: 8], b, b == int'(lb)); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        logic [127:0] v;
        logic acc;
        v = rand_vec();
        out_ready = 1'b1;
        send_vec(v, 4'd15, acc);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            n_cmp++; if (out_idx !== 4'(b) || out_data !== v[b*8 +: 8]) begin n_err++;
                $display("FAIL rst_pre[%0d]: got idx=%0d d=%h expected %0d/%h", b, out_idx, out_data, b, v[b*8 +: 8]); end
            @(posedge clk); #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_idx !== 4'd0) begin n_err++;
            $display("FAIL rst_async: got v=%b idx=%0d expected 0/0", out_valid, out_idx); end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0 || out_idx !== 4'd0 || in_ready !== 1'b1) begin n_err++;
                $display("FAIL rst_after[%0d]: got v=%b idx=%0d rdy=%b expected 0/0/1", c, out_valid, out_idx, in_ready); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignored_input();
        logic [127:0] v;
        logic acc;
        v = rand_vec();
        out_ready = 1'b1;
        send_vec(v, 4'd3, acc);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                in_data = ~v; in_len_m1 = 4'd15; in_valid = 1'b1;
            end
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== v[b*8 +: 8] || out_idx !== 4'(b) || out_last !== (b == 3)) begin n_err++;
                $display("FAIL ign_beat[%0d]: got v=%b d=%h idx=%0d last=%b expected 1/%h/%0d/%b",
                         b, out_valid, out_data, out_idx, out_last, v[b*8 +: 8], b, b == 3); end
            if (b == 2) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ign_in_ready: got %b expected 0", in_ready); end
            end
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = '0;
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ign_end_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;
    endtask

    // Scoreboard: each accepted vector becomes its list of expected beats.
    task automatic test_random();
        beat_t q[$];
        beat_t e;
        logic  exp_valid, exp_ready;
        for (int cyc = 0; cyc < 460; cyc++) begin
            if (cyc < 420) begin
                in_valid  = ($urandom_range(0, 2) == 0);
                in_data   = rand_vec();
                in_len_m1 = 4'($urandom_range(0, 15));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
            n_cmp++; if (out_valid !== exp_valid || in_ready !== exp_ready) begin n_err++;
                $display("FAIL rnd_hs[%0d]: got v=%b rdy=%b expected %b/%b", cyc, out_valid, in_ready, exp_valid, exp_ready); end
            if (exp_valid) begin
                n_cmp++; if (out_data !== q[0].w || out_idx !== q[0].idx || out_last !== q[0].last) begin n_err++;
                    $display("FAIL rnd_beat[%0d]: got d=%h idx=%0d last=%b expected %h/%0d/%b",
                             cyc, out_data, out_idx, out_last, q[0].w, q[0].idx, q[0].last); end
            end
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                for (int k = 0; k <= int'(in_len_m1); k++) begin
                    e.w    = in_data[k*8 +: 8];
                    e.idx  = 4'(k);
                    e.last = (k == int'(in_len_m1));
                    q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (q.size() != 0 || out_valid !== 1'b0) begin n_err++;
            $display("FAIL rnd_drain: got pending=%0d v=%b expected 0/0", q.size(), out_valid); end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_data   = '0;
        in_len_m1 = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        test_reset();
        test_first_vector();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        test_ignored_input();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
